// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared constants for the pipeline stall/flush controller: stall vector layout,
// FSM encodings and register-address geometry.
package pipeline_stall_ctrl_pkg;

   localparam int REG_ADDR_W = 5;
   localparam logic [REG_ADDR_W-1:0] ZERO_REG_ADDR = 5'd0;

   localparam int STALL_W   = 6;
   localparam int STALL_PC  = 0;
   localparam int STALL_IF  = 1;
   localparam int STALL_ID  = 2;
   localparam int STALL_EX  = 3;
   localparam int STALL_MEM = 4;
   localparam int STALL_WB  = 5;

   localparam logic [STALL_W-1:0] STALL_NONE     = 6'b000000;
   localparam logic [STALL_W-1:0] STALL_LOAD_USE = 6'b000111;
   localparam logic [STALL_W-1:0] STALL_MD       = 6'b001111;

   localparam int MD_CNT_W = 4;

   localparam logic [1:0] ST_IDLE    = 2'b00;
   localparam logic [1:0] ST_MD_BUSY = 2'b01;
   localparam logic [1:0] ST_MD_DONE = 2'b10;

   function automatic logic stall_active(input logic [STALL_W-1:0] s);
      return (s != STALL_NONE);
   endfunction

endpackage

// File: rtl/pipeline_stall_ctrl_if.sv
// Hazard-side inputs and stall/flush outputs of the stall controller.
// master = pipeline side, slave = controller side.
import pipeline_stall_ctrl_pkg::*;

interface pipeline_stall_ctrl_if #(parameter int CNT_W = 32);
   logic                    id_reg_read_en_1;
   logic [REG_ADDR_W-1:0]   id_reg_addr_1;
   logic                    id_reg_read_en_2;
   logic [REG_ADDR_W-1:0]   id_reg_addr_2;
   logic                    ex_write_reg_en;
   logic [REG_ADDR_W-1:0]   ex_write_reg_addr;
   logic                    ex_is_load;
   logic                    ex_md_start;
   logic                    exc_valid;
   logic [STALL_W-1:0]      stall;
   logic                    flush;
   logic                    md_busy;
   logic                    md_done;
   logic [CNT_W-1:0]        stall_cycles;

   modport master (
      output id_reg_read_en_1, id_reg_addr_1, id_reg_read_en_2, id_reg_addr_2,
             ex_write_reg_en, ex_write_reg_addr, ex_is_load, ex_md_start, exc_valid,
      input  stall, flush, md_busy, md_done, stall_cycles
   );

   modport slave (
      input  id_reg_read_en_1, id_reg_addr_1, id_reg_read_en_2, id_reg_addr_2,
             ex_write_reg_en, ex_write_reg_addr, ex_is_load, ex_md_start, exc_valid,
      output stall, flush, md_busy, md_done, stall_cycles
   );
endinterface

// File: rtl/pipeline_stall_ctrl_load_use_detect.sv
// Combinational load-use hazard detector: a load in EX whose destination is read
// by an enabled ID operand; register 0 is hard-wired and never creates a hazard.
import pipeline_stall_ctrl_pkg::*;

module load_use_detect (
   input  logic                  id_reg_read_en_1,
   input  logic [REG_ADDR_W-1:0] id_reg_addr_1,
   input  logic                  id_reg_read_en_2,
   input  logic [REG_ADDR_W-1:0] id_reg_addr_2,
   input  logic                  ex_write_reg_en,
   input  logic [REG_ADDR_W-1:0] ex_write_reg_addr,
   input  logic                  ex_is_load,
   output logic                  load_use
);

   logic hit_1_s;
   logic hit_2_s;
   logic ex_load_dest_s;

   assign hit_1_s        = id_reg_read_en_1 && (id_reg_addr_1 == ex_write_reg_addr);
   assign hit_2_s        = id_reg_read_en_2 && (id_reg_addr_2 == ex_write_reg_addr);
   assign ex_load_dest_s = ex_is_load && ex_write_reg_en && (ex_write_reg_addr != ZERO_REG_ADDR);
   assign load_use       = ex_load_dest_s && (hit_1_s || hit_2_s);

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush controller: load-use bubbles, mul/div EX occupancy,
// exception flush and a saturating stall-cycle counter.
import pipeline_stall_ctrl_pkg::*;

module pipeline_stall_ctrl #(
   parameter int MD_LATENCY = 4,
   parameter int CNT_W      = 32
) (
   input logic                   clk,
   input logic                   rst_n,
   pipeline_stall_ctrl_if.slave  bus
);

   // First cycle already stalls from IDLE, so BUSY needs MD_LATENCY-2 cycles: load MD_LATENCY-3.
   localparam logic [MD_CNT_W-1:0] MD_LOAD = (MD_LATENCY > 2) ? MD_CNT_W'(MD_LATENCY - 3) : 4'd0;

   logic [1:0]          state_r;
   logic [1:0]          state_nxt_s;
   logic [MD_CNT_W-1:0] cnt_r;
   logic [MD_CNT_W-1:0] cnt_nxt_s;
   logic [CNT_W-1:0]    stall_cycles_r;
   logic                md_stall_s;
   logic                load_use_s;
   logic [STALL_W-1:0]  stall_s;

   load_use_detect u_load_use_detect (
      .id_reg_read_en_1  (bus.id_reg_read_en_1),
      .id_reg_addr_1     (bus.id_reg_addr_1),
      .id_reg_read_en_2  (bus.id_reg_read_en_2),
      .id_reg_addr_2     (bus.id_reg_addr_2),
      .ex_write_reg_en   (bus.ex_write_reg_en),
      .ex_write_reg_addr (bus.ex_write_reg_addr),
      .ex_is_load        (bus.ex_is_load),
      .load_use          (load_use_s)
   );

   assign md_stall_s = ((state_r == ST_IDLE) && bus.ex_md_start) || (state_r == ST_MD_BUSY);

   // Mul/div occupancy FSM next state; an exception abandons the instruction in EX.
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      if (bus.exc_valid) begin
         state_nxt_s = ST_IDLE;
         cnt_nxt_s   = 4'd0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (bus.ex_md_start) begin
                  if (MD_LATENCY == 2) begin
                     state_nxt_s = ST_MD_DONE;
                  end else begin
                     state_nxt_s = ST_MD_BUSY;
                     cnt_nxt_s   = MD_LOAD;
                  end
               end else begin
                  state_nxt_s = ST_IDLE;
               end
            end
            ST_MD_BUSY: begin
               if (cnt_r == 4'd0) begin
                  state_nxt_s = ST_MD_DONE;
               end else begin
                  cnt_nxt_s = cnt_r - 4'd1;
               end
            end
            ST_MD_DONE: begin
               state_nxt_s = ST_IDLE;
            end
            default: begin
               state_nxt_s = ST_IDLE;
               cnt_nxt_s   = 4'd0;
            end
         endcase
      end
   end

   // Stall vector by priority: exception, then mul/div, then load-use.
   always_comb begin
      stall_s = STALL_NONE;
      if (bus.exc_valid) begin
         stall_s = STALL_NONE;
      end else if (md_stall_s) begin
         stall_s = STALL_MD;
      end else if (load_use_s) begin
         stall_s = STALL_LOAD_USE;
      end else begin
         stall_s = STALL_NONE;
      end
   end

   // FSM state and occupancy counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
         cnt_r   <= 4'd0;
      end else begin
         state_r <= state_nxt_s;
         cnt_r   <= cnt_nxt_s;
      end
   end

   // Saturating count of stalled cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cycles_r <= {CNT_W{1'b0}};
      end else if (stall_active(stall_s) && (stall_cycles_r != {CNT_W{1'b1}})) begin
         stall_cycles_r <= stall_cycles_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         stall_cycles_r <= stall_cycles_r;
      end
   end

   assign bus.stall        = rst_n ? stall_s : STALL_NONE;
   assign bus.flush        = rst_n && bus.exc_valid;
   assign bus.md_busy      = rst_n && md_stall_s;
   assign bus.md_done      = rst_n && (state_r == ST_MD_DONE) && !bus.exc_valid;
   assign bus.stall_cycles = stall_cycles_r;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl: two builds (MD_LATENCY=4/CNT_W=32 and
// MD_LATENCY=2/CNT_W=4) share one stimulus and are checked against an age-based model.
import pipeline_stall_ctrl_pkg::*;

module tb_pipeline_stall_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       re1, re2, wen, ld, mds, exc;
   logic [4:0] a1, a2, wa;

   always #5 clk = ~clk;

   pipeline_stall_ctrl_if #(.CNT_W(32)) if0 ();
   pipeline_stall_ctrl_if #(.CNT_W(4))  if1 ();

   assign if0.id_reg_read_en_1 = re1;  assign if1.id_reg_read_en_1 = re1;
   assign if0.id_reg_addr_1 = a1;      assign if1.id_reg_addr_1 = a1;
   assign if0.id_reg_read_en_2 = re2;  assign if1.id_reg_read_en_2 = re2;
   assign if0.id_reg_addr_2 = a2;      assign if1.id_reg_addr_2 = a2;
   assign if0.ex_write_reg_en = wen;   assign if1.ex_write_reg_en = wen;
   assign if0.ex_write_reg_addr = wa;  assign if1.ex_write_reg_addr = wa;
   assign if0.ex_is_load = ld;         assign if1.ex_is_load = ld;
   assign if0.ex_md_start = mds;       assign if1.ex_md_start = mds;
   assign if0.exc_valid = exc;         assign if1.exc_valid = exc;

   pipeline_stall_ctrl #(.MD_LATENCY(4), .CNT_W(32)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
   pipeline_stall_ctrl #(.MD_LATENCY(2), .CNT_W(4))  dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Model: age = cycles since the mul/div entered EX (-1 = none). Stalled while
   // age <= LAT-2, done at age LAT-1; exceptions drop the instruction.
   int     lat_m[2] = '{4, 2};
   longint cmax_m[2] = '{64'hFFFF_FFFF, 64'hF};
   int     age_m[2];
   longint cnt_m[2];

   function automatic void model_eval(input int age, input int lat,
                                      output logic [5:0] st, output logic fl,
                                      output logic busy, output logic done, output int nxt);
      int   a;
      logic lu, md;
      a  = (age < 0 && mds) ? 0 : age;
      lu = ld && wen && (wa != 5'd0) && ((re1 && a1 == wa) || (re2 && a2 == wa));
      md = (a >= 0) && (a <= lat - 2);
      fl   = exc;
      busy = md;
      done = (a == lat - 1) && !exc;
      st   = exc ? 6'b000000 : md ? 6'b001111 : lu ? 6'b000111 : 6'b000000;
      nxt  = exc ? -1 : ((a >= 0 && a < lat - 1) ? a + 1 : -1);
   endfunction

   // Model state advance on each clock edge.
   always @(posedge clk or negedge rst_n) begin
      logic [5:0] st;
      logic fl, bz, dn;
      int nx;
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            age_m[i] <= -1;
            cnt_m[i] <= 0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            model_eval(age_m[i], lat_m[i], st, fl, bz, dn, nx);
            if (st != 6'd0 && cnt_m[i] < cmax_m[i]) cnt_m[i] <= cnt_m[i] + 1;
            age_m[i] <= nx;
         end
      end
   end

   // Every-cycle comparison of both builds against the model, on the falling edge.
   always @(negedge clk) begin
      logic [5:0] st;
      logic fl, bz, dn;
      int nx;
      for (int i = 0; i < 2; i++) begin
         model_eval(age_m[i], lat_m[i], st, fl, bz, dn, nx);
         if (!rst_n) begin
            st = 6'd0; fl = 1'b0; bz = 1'b0; dn = 1'b0;
         end
         chk($sformatf("dut%0d.stall", i), 64'(i == 0 ? if0.stall : if1.stall), 64'(st));
         chk($sformatf("dut%0d.flush", i), 64'(i == 0 ? if0.flush : if1.flush), 64'(fl));
         chk($sformatf("dut%0d.md_busy", i), 64'(i == 0 ? if0.md_busy : if1.md_busy), 64'(bz));
         chk($sformatf("dut%0d.md_done", i), 64'(i == 0 ? if0.md_done : if1.md_done), 64'(dn));
         chk($sformatf("dut%0d.stall_cycles", i),
             (i == 0) ? 64'(if0.stall_cycles) : 64'(if1.stall_cycles), 64'(cnt_m[i]));
      end
   end

   task automatic set_idle();
      re1 = 1'b0; re2 = 1'b0; wen = 1'b0; ld = 1'b0; mds = 1'b0; exc = 1'b0;
      a1 = 5'd0; a2 = 5'd0; wa = 5'd0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_lu(input logic [4:0] r);
      ld = 1'b1; wen = 1'b1; wa = r; re1 = 1'b1; a1 = r;
   endtask

   initial begin
      set_idle();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      @(negedge clk);
      chk("reset_stall", 64'(if0.stall), 64'h0);
      chk("reset_count", 64'(if0.stall_cycles), 64'h0);

      // load-use hit for one cycle
      step(); set_lu(5'd5);
      @(negedge clk); chk("lu_stall", 64'(if0.stall), 64'b000111);
      step(); ld = 1'b0;
      @(negedge clk); chk("lu_clear", 64'(if0.stall), 64'h0);
      chk("lu_count", 64'(if0.stall_cycles), 64'd1);

      // negatives: register 0, then disabled read port
      step(); set_idle(); ld = 1'b1; wen = 1'b1; wa = 5'd0; re2 = 1'b1; a2 = 5'd0;
      @(negedge clk); chk("lu_r0", 64'(if0.stall), 64'h0);
      step(); wa = 5'd7; a1 = 5'd7; re1 = 1'b0; re2 = 1'b1; a2 = 5'd3;
      @(negedge clk); chk("lu_disabled", 64'(if0.stall), 64'h0);

      // mul/div, latency 4 on dut0
      step(); set_idle(); mds = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk($sformatf("md_stall_t%0d", k), 64'(if0.stall), (k < 3) ? 64'b001111 : 64'h0);
         chk($sformatf("md_done_t%0d", k), 64'(if0.md_done), (k == 3) ? 64'd1 : 64'd0);
         step();
      end
      mds = 1'b0;
      @(negedge clk); chk("md_idle_busy", 64'(if0.md_busy), 64'h0);
      chk("md_idle_done", 64'(if0.md_done), 64'h0);
      chk("md_count", 64'(if0.stall_cycles), 64'd4);

      // exception while mul/div occupies EX
      step(); mds = 1'b1;
      @(negedge clk); chk("exc_md_t0", 64'(if0.stall), 64'b001111);
      step(); exc = 1'b1;
      @(negedge clk); chk("exc_flush", 64'(if0.flush), 64'd1);
      chk("exc_stall", 64'(if0.stall), 64'h0);
      step(); exc = 1'b0; mds = 1'b0;
      @(negedge clk); chk("exc_no_done", 64'(if0.md_done), 64'h0);
      chk("exc_idle", 64'(if0.md_busy), 64'h0);
      step();
      @(negedge clk); chk("exc_no_done2", 64'(if0.md_done), 64'h0);
      chk("exc_count", 64'(if0.stall_cycles), 64'd5);

      // load-use together with exception
      step(); set_lu(5'd9); exc = 1'b1;
      @(negedge clk); chk("prio_flush", 64'(if0.flush), 64'd1);
      chk("prio_stall", 64'(if0.stall), 64'h0);
      step(); set_idle();
      @(negedge clk); chk("prio_count", 64'(if0.stall_cycles), 64'd5);

      // drive dut1 (CNT_W=4) into saturation
      step(); set_lu(5'd12);
      repeat (16) step();
      set_idle();
      @(negedge clk); chk("sat_cnt1", 64'(if1.stall_cycles), 64'hF);
      chk("sat_cnt0", 64'(if0.stall_cycles), 64'd21);
      step(); set_lu(5'd12);
      repeat (3) step();
      set_idle();
      @(negedge clk); chk("sat_hold", 64'(if1.stall_cycles), 64'hF);
      chk("sat_cnt0b", 64'(if0.stall_cycles), 64'd24);

      // asynchronous reset in the middle of a mul/div
      step(); mds = 1'b1;
      step();
      #3 rst_n = 1'b0;
      #1;
      chk("arst_stall0", 64'(if0.stall), 64'h0);
      chk("arst_busy0", 64'(if0.md_busy), 64'h0);
      chk("arst_flush0", 64'(if0.flush), 64'h0);
      chk("arst_done0", 64'(if0.md_done), 64'h0);
      chk("arst_cnt0", 64'(if0.stall_cycles), 64'h0);
      chk("arst_stall1", 64'(if1.stall), 64'h0);
      repeat (2) @(posedge clk);
      #2 mds = 1'b0;
      #1 rst_n = 1'b1;
      @(negedge clk); chk("post_rst_busy", 64'(if0.md_busy), 64'h0);
      chk("post_rst_done", 64'(if0.md_done), 64'h0);
      chk("post_rst_cnt", 64'(if0.stall_cycles), 64'h0);
      step(); mds = 1'b1;
      @(negedge clk); chk("post_rst_md", 64'(if0.stall), 64'b001111);
      repeat (4) step();
      mds = 1'b0;
      repeat (3) step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
